wb_pipe_n: RTL and testbench
============================

Name: wb_pipe_n

Overview:
- Parametrised successor to the single-stage writeback pipeline register.
- Carries register-file write requests (enable, address, data) through DEPTH register stages before they reach the register file.
- Adds stall and flush controls, x0 write suppression, and NUM_Q forwarding query ports that return the youngest in-flight matching write for data-hazard resolution.
- Sits between the memory-access stage and the register file.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 5, register-file address width in bits.
- DEPTH, 2, number of pipeline stages; legal range 1..4.
- NUM_Q, 2, number of forwarding query ports; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- _rst  in  1  asynchronous active-low reset.
- reg_w_en_in  in  1  write request from the memory-access stage.
- rd_addr_in  in  ADDR_W  destination register address.
- reg_data_in  in  DATA_W  write data.
- stall  in  1  hold all stages and suppress retirement.
- flush  in  1  kill all in-flight writes and the current input.
- reg_w_en_out  out  1  register-file write enable.
- rd_addr_out  out  ADDR_W  register-file write address.
- reg_data_out  out  DATA_W  register-file write data.
- q_addr  in  NUM_Q*ADDR_W  query addresses, packed; query i occupies [i*ADDR_W +: ADDR_W].
- q_hit  out  NUM_Q  query i matches an in-flight write.
- q_data  out  NUM_Q*DATA_W  forwarded data for each query, packed the same way.
- busy  out  1  at least one stage holds a valid write.

Behaviour:
- Storage: stages S0..S(DEPTH-1). S0 is youngest; S(DEPTH-1) is oldest and drives the register-file outputs. Each stage holds v (1 bit), addr, and data.
- Reset (asynchronous, _rst=0): every stage clears to v=0, addr=0, data=0 immediately, independent of clk. Outputs while in reset: reg_w_en_out=0, rd_addr_out=0, reg_data_out=0, q_hit=0, q_data=0, busy=0. Reset asserted mid-operation discards every in-flight write, and no write retires in that cycle.
- Input qualification: in_v = reg_w_en_in & (rd_addr_in != 0). Writes to x0 never enter the pipe as valid; their addr and data are still captured.
- Clock edge priority, evaluated in order (flush > stall > advance):
  - flush=1: every stage v <= 0; addr and data keep their values; the input is discarded.
  - else stall=1: all stages hold.
  - else advance: S0 <= {in_v, rd_addr_in, reg_data_in}, and S(k) <= S(k-1) for k = 1..DEPTH-1.
- Register-file outputs (combinational from the oldest stage):
  - reg_w_en_out = S(DEPTH-1).v & ~stall & ~flush.
  - rd_addr_out = S(DEPTH-1).addr; reg_data_out = S(DEPTH-1).data, driven regardless of v.
  - A write retires exactly once, in the first cycle its entry is in S(DEPTH-1) with stall=0 and flush=0.
  - The entry in S(DEPTH-1) at a flush edge is killed and never retires.
- Latency:
  - A write accepted at edge t reaches S(DEPTH-1) after edge t+DEPTH-1.
  - With no stall it is written to the register file at edge t+DEPTH.
  - Each stall cycle adds one cycle.
  - With DEPTH=1 the block matches the single-stage register, plus stall, flush, and query.
- Forwarding (combinational, per query i):
  - Match condition for stage k: S(k).v & (S(k).addr == q_addr[i]) & (q_addr[i] != 0).
  - q_hit[i] = OR of the match condition over all k.
  - q_data[i] = data of the lowest-index (youngest) matching stage; 0 when there is no hit.
  - Queries see stage contents only; the same-cycle input is not forwarded.
  - Query results ignore stall and flush, since stages hold their values until the edge.
- busy = OR of all S(k).v.
- Back-to-back writes to the same address must retire in order, oldest first.

Test Plan:
- Reset: DEPTH=2; drive writes (w_en=1, addr=3, data=0xAAAA0003), then pulse _rst low between clock edges. Required: all outputs 0 immediately; after _rst is released, no write to r3 ever appears.
- Latency and ordering: DEPTH=2; accept w_en=1, addr=5, data=0x11 at edge 0 and w_en=1, addr=5, data=0x22 at edge 1. Required: reg_w_en_out=1, rd_addr_out=5, data=0x11 in the cycle after edge 1 (retires at edge 2); data=0x22 in the cycle after edge 2 (retires at edge 3).
- x0 suppression: input w_en=1, addr=0, data=0xDEAD. Required: busy stays 0, reg_w_en_out is never 1, and a query on q_addr=0 gives hit=0, data=0.
- Stall: entry addr=7, data=0x77 sits in S1 (DEPTH=2); hold stall=1 for 3 cycles. Required: reg_w_en_out=0 for all 3 cycles; the query for r7 keeps hit=1, data=0x77; after stall drops, exactly one retirement occurs.
- Flush over stall: S0 holds addr=9, data=0x9, S1 holds addr=4, data=0x4, and the input is addr=2; assert stall=1 and flush=1 at the same edge. Required: reg_w_en_out=0 in that cycle; afterwards busy=0, queries on 9, 4, and 2 all miss, and nothing retires.
- Youngest-wins forwarding: DEPTH=3, NUM_Q=2; S2 holds r6=0x60, S1 holds r6=0x61, S0 holds r8=0x80. Query q0=6, q1=8. Required: q_hit=2'b11, q_data0=0x61, q_data1=0x80.

Source files
------------

// File: rtl/wb_pipe_n.sv
// wb_pipe_n: DEPTH-stage writeback pipeline between the memory-access stage
// and the register file. Carries {valid, addr, data} write requests, supports
// stall and flush, suppresses writes to x0, and answers NUM_Q forwarding
// queries with the youngest in-flight write to the queried register.
module wb_pipe_n #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2,  // 1..4
  parameter int unsigned NUM_Q  = 2   // 1..4
) (
  input  logic                      clk,
  input  logic                      _rst,
  input  logic                      reg_w_en_in,
  input  logic [ADDR_W-1:0]         rd_addr_in,
  input  logic [DATA_W-1:0]         reg_data_in,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      reg_w_en_out,
  output logic [ADDR_W-1:0]         rd_addr_out,
  output logic [DATA_W-1:0]         reg_data_out,
  input  logic [NUM_Q*ADDR_W-1:0]   q_addr,
  output logic [NUM_Q-1:0]          q_hit,
  output logic [NUM_Q*DATA_W-1:0]   q_data,
  output logic                      busy
);

  // Stage 0 is youngest, stage DEPTH-1 is oldest and feeds the register file.
  logic [DEPTH-1:0]  s_v;
  logic [ADDR_W-1:0] s_addr [DEPTH];
  logic [DATA_W-1:0] s_data [DEPTH];

  logic in_v;
  assign in_v = reg_w_en_in & (rd_addr_in != '0);

  // Stage registers: flush kills valids (payload kept), stall holds, else shift.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      s_v <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        s_addr[k] <= '0;
        s_data[k] <= '0;
      end
    end else if (flush) begin
      s_v <= '0;
    end else if (!stall) begin
      s_v[0]    <= in_v;
      s_addr[0] <= rd_addr_in;
      s_data[0] <= reg_data_in;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        s_v[k]    <= s_v[k-1];
        s_addr[k] <= s_addr[k-1];
        s_data[k] <= s_data[k-1];
      end
    end
  end

  // A write retires only in a cycle where the oldest stage actually advances.
  assign reg_w_en_out = s_v[DEPTH-1] & ~stall & ~flush;
  assign rd_addr_out  = s_addr[DEPTH-1];
  assign reg_data_out = s_data[DEPTH-1];
  assign busy         = |s_v;

  // Forwarding lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    q_hit  = '0;
    q_data = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      for (int unsigned k = DEPTH; k > 0; k--) begin
        if (s_v[k-1] && (s_addr[k-1] == q_addr[i*ADDR_W +: ADDR_W]) &&
            (q_addr[i*ADDR_W +: ADDR_W] != '0)) begin
          q_hit[i]                    = 1'b1;
          q_data[i*DATA_W +: DATA_W]  = s_data[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_pipe_n.sv
// tb_wb_pipe_n: directed bench for wb_pipe_n. Two instances (DEPTH=2 and
// DEPTH=3) share the same input stimulus; each step states which one it checks.
module tb_wb_pipe_n;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NQ = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           w_en;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  data;
  logic           stall;
  logic           flush;
  logic [NQ*AW-1:0] qa;

  logic           wen2, wen3;
  logic [AW-1:0]  aout2, aout3;
  logic [DW-1:0]  dout2, dout3;
  logic [NQ-1:0]  hit2, hit3;
  logic [NQ*DW-1:0] qd2, qd3;
  logic           busy2, busy3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_pipe_n #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(2), .NUM_Q(NQ)) u2 (
    .clk(clk), ._rst(rst_n), .reg_w_en_in(w_en), .rd_addr_in(addr),
    .reg_data_in(data), .stall(stall), .flush(flush),
    .reg_w_en_out(wen2), .rd_addr_out(aout2), .reg_data_out(dout2),
    .q_addr(qa), .q_hit(hit2), .q_data(qd2), .busy(busy2)
  );

  wb_pipe_n #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(3), .NUM_Q(NQ)) u3 (
    .clk(clk), ._rst(rst_n), .reg_w_en_in(w_en), .rd_addr_in(addr),
    .reg_data_in(data), .stall(stall), .flush(flush),
    .reg_w_en_out(wen3), .rd_addr_out(aout3), .reg_data_out(dout3),
    .q_addr(qa), .q_hit(hit3), .q_data(qd3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    w_en = en;
    addr = a;
    data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    qa    = '0;
    drive(1'b0, '0, '0);
    #12;
    chk("rst_init_wen", {63'd0, wen2}, 64'd0);
    chk("rst_init_busy", {63'd0, busy2}, 64'd0);
    rst_n = 1'b1;

    // ---- reset mid-operation discards r3 writes ----
    drive(1'b1, 5'd3, 32'hAAAA0003);
    qa = {5'd3, 5'd3};
    tick();
    tick();
    drive(1'b0, '0, '0);
    chk("rst_pre_busy", {63'd0, busy2}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wen", {63'd0, wen2}, 64'd0);
    chk("rst_addr", {59'd0, aout2}, 64'd0);
    chk("rst_data", {32'd0, dout2}, 64'd0);
    chk("rst_qhit", {62'd0, hit2}, 64'd0);
    chk("rst_qdata", qd2, 64'd0);
    chk("rst_busy", {63'd0, busy2}, 64'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_retire", {63'd0, wen2}, 64'd0);
    end

    // ---- latency and same-address ordering ----
    drive(1'b1, 5'd5, 32'h11);
    tick();                          // edge 0
    drive(1'b1, 5'd5, 32'h22);
    tick();                          // edge 1
    drive(1'b0, '0, '0);
    chk("lat_wen_a", {63'd0, wen2}, 64'd1);
    chk("lat_addr_a", {59'd0, aout2}, 64'd5);
    chk("lat_data_a", {32'd0, dout2}, 64'h11);
    chk("lat3_wen_early", {63'd0, wen3}, 64'd0);
    tick();                          // edge 2
    chk("lat_wen_b", {63'd0, wen2}, 64'd1);
    chk("lat_addr_b", {59'd0, aout2}, 64'd5);
    chk("lat_data_b", {32'd0, dout2}, 64'h22);
    chk("lat3_wen", {63'd0, wen3}, 64'd1);
    chk("lat3_data", {32'd0, dout3}, 64'h11);
    tick();                          // edge 3
    chk("lat_done_wen", {63'd0, wen2}, 64'd0);
    chk("lat_done_busy", {63'd0, busy2}, 64'd0);

    // ---- x0 writes never become valid ----
    tick();
    drive(1'b1, 5'd0, 32'hDEAD);
    qa = {5'd0, 5'd0};
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("x0_busy", {63'd0, busy2}, 64'd0);
      chk("x0_wen", {63'd0, wen2}, 64'd0);
      chk("x0_qhit", {62'd0, hit2}, 64'd0);
      chk("x0_qdata", qd2, 64'd0);
    end
    drive(1'b0, '0, '0);
    tick();

    // ---- stall holds r7 in the oldest stage ----
    drive(1'b1, 5'd7, 32'h77);
    tick();
    drive(1'b0, '0, '0);
    tick();                          // r7 now in S1
    stall = 1'b1;
    qa = {5'd0, 5'd7};
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_wen", {63'd0, wen2}, 64'd0);
      chk("stall_qhit", {62'd0, hit2}, 64'd1);
      chk("stall_qdata", qd2, 64'h77);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("stall_retire_wen", {63'd0, wen2}, 64'd1);
    chk("stall_retire_addr", {59'd0, aout2}, 64'd7);
    chk("stall_retire_data", {32'd0, dout2}, 64'h77);
    tick();
    chk("stall_once_wen", {63'd0, wen2}, 64'd0);
    chk("stall_once_busy", {63'd0, busy2}, 64'd0);

    // ---- flush beats stall ----
    drive(1'b1, 5'd4, 32'h4);
    tick();
    drive(1'b1, 5'd9, 32'h9);
    tick();                          // S1=r4, S0=r9
    drive(1'b1, 5'd2, 32'h2);
    stall = 1'b1;
    flush = 1'b1;
    qa = {5'd9, 5'd4};
    #1;
    chk("flush_wen", {63'd0, wen2}, 64'd0);
    chk("flush_pre_qhit", {62'd0, hit2}, 64'd3);
    chk("flush_pre_qdata", qd2, {32'h9, 32'h4});
    tick();
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    chk("flush_busy", {63'd0, busy2}, 64'd0);
    chk("flush_q94_hit", {62'd0, hit2}, 64'd0);
    chk("flush_q94_data", qd2, 64'd0);
    qa = {5'd2, 5'd2};
    #1;
    chk("flush_q2_hit", {62'd0, hit2}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("flush_no_retire", {63'd0, wen2}, 64'd0);
    end

    // ---- youngest-wins forwarding (DEPTH=3) ----
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(1'b1, 5'd6, 32'h60);
    tick();
    drive(1'b1, 5'd6, 32'h61);
    tick();
    drive(1'b1, 5'd8, 32'h80);
    tick();
    drive(1'b0, '0, '0);
    qa = {5'd8, 5'd6};
    #1;
    chk("fwd3_qhit", {62'd0, hit3}, 64'd3);
    chk("fwd3_qdata", qd3, {32'h80, 32'h61});
    chk("fwd3_wen_r6_60", {31'd0, dout3, wen3}, {31'd0, 32'h60, 1'b1});
    chk("fwd2_qdata", qd2, {32'h80, 32'h61});
    qa = {5'd3, 5'd6};
    #1;
    chk("fwd3_partial_hit", {62'd0, hit3}, 64'd1);
    chk("fwd3_partial_data", qd3, {32'h0, 32'h61});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
